// File: rtl/spirose_pkg.sv
// spirose_pkg: shared constants and types for the LED framebuffer path.
// Module parameters default to these values.
package spirose_pkg;
    localparam int DRIVER_COUNT = 30;
    localparam int SLICE_CYCLES = 512;
    localparam int DATA_CYCLES  = 432;
    localparam int N_SLICES     = 128;
    localparam int RAM_LATENCY  = 2;

    typedef logic [DRIVER_COUNT-1:0] fb_word_t;
    typedef enum logic [1:0] {IDLE, ARM, RUN} fb_state_t;
endpackage

// File: rtl/framebuffer_streamer_if.sv
// framebuffer_streamer_if: read port between the streamer and the slice RAM.
// The address is laid out as {bank, slice, word}.
interface framebuffer_streamer_if #(
    parameter int AW = 17
);
    import spirose_pkg::*;

    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    fb_word_t      ram_rdata;

    modport master (output ram_addr, ram_rd, input ram_rdata);
    modport slave  (input ram_addr, ram_rd, output ram_rdata);
endinterface

// File: rtl/fb_read_pipe.sv
// fb_read_pipe: delays the read strobe by the RAM latency and registers
// ram_rdata into the driver word only when it belongs to an issued read.
module fb_read_pipe #(
    parameter int RAM_LATENCY = 2
) (
    input  logic                  clk_33,
    input  logic                  nrst,
    input  logic                  rd,
    input  spirose_pkg::fb_word_t rdata,
    output spirose_pkg::fb_word_t dat
);
    logic valid;

    if (RAM_LATENCY == 1) begin : g_direct
        assign valid = rd;
    end else begin : g_pipe
        logic [RAM_LATENCY-2:0] sr;

        always_ff @(posedge clk_33 or negedge nrst) begin
            if (!nrst) sr <= '0;
            else       sr <= (RAM_LATENCY-1)'({sr, rd});
        end

        assign valid = sr[RAM_LATENCY-2];
    end

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) dat <= '0;
        else       dat <= valid ? rdata : '0;
    end
endmodule

// File: rtl/framebuffer_streamer.sv
// framebuffer_streamer: turns the banked slice RAM into the per-cycle driver
// word stream and keeps a free-running slice period once armed.
module framebuffer_streamer #(
    parameter int SLICE_CYCLES = spirose_pkg::SLICE_CYCLES,
    parameter int DATA_CYCLES  = spirose_pkg::DATA_CYCLES,
    parameter int N_SLICES     = spirose_pkg::N_SLICES,
    parameter int RAM_LATENCY  = spirose_pkg::RAM_LATENCY
) (
    input  logic                   clk_33,
    input  logic                   nrst,
    input  logic                   frame_ready,
    input  logic                   position_sync,
    framebuffer_streamer_if.master ram,
    output spirose_pkg::fb_word_t  framebuffer_dat,
    output logic                   framebuffer_sync,
    output logic                   read_bank,
    output logic                   frame_done,
    output logic                   resync_err
);
    import spirose_pkg::*;

    localparam int BLANK = SLICE_CYCLES - DATA_CYCLES;
    localparam int PW = $clog2(SLICE_CYCLES);
    localparam int SW = $clog2(N_SLICES);
    localparam int WW = $clog2(DATA_CYCLES);
    localparam int QW = $clog2(SLICE_CYCLES + RAM_LATENCY + 1) + 1;
    localparam logic [PW-1:0] P_LAST = PW'(SLICE_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(N_SLICES - 1);
    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_ARM  = 2'(ARM);
    localparam logic [1:0] ST_RUN  = 2'(RUN);

    logic [1:0]    state;
    logic [PW-1:0] p;
    logic [SW-1:0] slice;
    logic          realign;
    logic          swap_pending;
    logic          run;
    logic          wrap;
    logic          frame_end;
    logic          swap;
    logic [SW-1:0] up_slice;
    logic          up_bank;
    logic [QW-1:0] pa;
    logic [SW-1:0] rd_slice;
    logic          rd_bank;
    logic          rd_hit;
    logic [WW-1:0] rd_word;

    assign run       = state == ST_RUN;
    assign wrap      = run && p == P_LAST;
    assign frame_end = slice == S_LAST || realign;
    assign swap      = frame_end && (swap_pending || frame_ready);
    assign up_slice  = frame_end ? '0 : slice + 1'b1;
    assign up_bank   = read_bank ^ swap;

    // pa is the period position whose word the read issued now will feed;
    // past the period end it belongs to the upcoming slice and bank.
    always_comb begin
        pa       = QW'(RAM_LATENCY);
        rd_slice = '0;
        rd_bank  = read_bank;
        if (run) begin
            pa       = QW'(p) + QW'(RAM_LATENCY + 1);
            rd_slice = slice;
            if (pa >= QW'(SLICE_CYCLES)) begin
                pa       = pa - QW'(SLICE_CYCLES);
                rd_slice = up_slice;
                rd_bank  = up_bank;
            end
        end
        rd_hit  = (run || state == ST_ARM) && pa >= QW'(BLANK)
                  && pa < QW'(SLICE_CYCLES);
        rd_word = WW'(pa - QW'(BLANK));
    end

    always_ff @(posedge clk_33 or negedge nrst) begin
        if (!nrst) begin
            state            <= ST_IDLE;
            p                <= '0;
            slice            <= '0;
            realign          <= 1'b0;
            swap_pending     <= 1'b0;
            read_bank        <= 1'b0;
            framebuffer_sync <= 1'b0;
            frame_done       <= 1'b0;
            resync_err       <= 1'b0;
            ram.ram_rd       <= 1'b0;
            ram.ram_addr     <= '0;
        end else begin
            framebuffer_sync <= 1'b0;
            frame_done       <= 1'b0;
            resync_err       <= 1'b0;
            ram.ram_rd       <= rd_hit;
            if (rd_hit) ram.ram_addr <= {rd_bank, rd_slice, rd_word};
            unique case (1'b1)
                state == ST_IDLE: begin
                    if (frame_ready) begin
                        state            <= ST_ARM;
                        read_bank        <= 1'b0;
                        framebuffer_sync <= 1'b1;
                    end
                end
                state == ST_ARM: begin
                    state <= ST_RUN;
                    p     <= '0;
                    slice <= '0;
                end
                default: begin
                    p                <= wrap ? '0 : p + 1'b1;
                    framebuffer_sync <= p == P_LAST - 1'b1;
                    if (wrap) begin
                        slice   <= up_slice;
                        realign <= position_sync;
                        if (frame_end) begin
                            frame_done   <= 1'b1;
                            resync_err   <= realign && slice != S_LAST;
                            read_bank    <= up_bank;
                            swap_pending <= 1'b0;
                        end else begin
                            swap_pending <= swap_pending | frame_ready;
                        end
                    end else begin
                        realign      <= realign | position_sync;
                        swap_pending <= swap_pending | frame_ready;
                    end
                end
            endcase
        end
    end

    fb_read_pipe #(
        .RAM_LATENCY(RAM_LATENCY)
    ) u_read_pipe (
        .clk_33(clk_33),
        .nrst  (nrst),
        .rd    (ram.ram_rd),
        .rdata (ram.ram_rdata),
        .dat   (framebuffer_dat)
    );
endmodule

// File: tb/tb_framebuffer_streamer.sv
// tb_framebuffer_streamer: three streamers (RAM latency 1, 2, 3) with 4 slices
// share one stimulus; each has its own RAM model returning hashed addresses.
module tb_framebuffer_streamer;
    localparam int NS = 4;
    localparam int SC = 512;
    localparam int DC = 432;
    localparam int BL = SC - DC;
    localparam int AW = 12;
    localparam logic [29:0] JUNK = 30'h15555555;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic frame_ready = 1'b0;
    logic position_sync = 1'b0;

    logic [29:0]   dat   [3];
    logic          sync  [3];
    logic          bank  [3];
    logic          done  [3];
    logic          err   [3];
    logic          rd    [3];
    logic [AW-1:0] addr  [3];

    int checks = 0;
    int errors = 0;
    int pos = 0;

    always #5 clk = ~clk;

    function automatic logic [29:0] word_of(input logic [AW-1:0] a);
        return {a, a ^ 12'hA5C, 6'h2D};
    endfunction

    function automatic logic [AW-1:0] mk(input logic b, input int s, input int w);
        return {b, 2'(s), 9'(w)};
    endfunction

    function automatic int at(input int period, input int p);
        return period * SC + p;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int L = k + 1;
        framebuffer_streamer_if #(.AW(AW)) bus ();

        framebuffer_streamer #(
            .SLICE_CYCLES(SC),
            .DATA_CYCLES (DC),
            .N_SLICES    (NS),
            .RAM_LATENCY (L)
        ) dut (
            .clk_33          (clk),
            .nrst            (nrst),
            .frame_ready     (frame_ready),
            .position_sync   (position_sync),
            .ram             (bus),
            .framebuffer_dat (dat[k]),
            .framebuffer_sync(sync[k]),
            .read_bank       (bank[k]),
            .frame_done      (done[k]),
            .resync_err      (err[k])
        );

        assign rd[k]   = bus.ram_rd;
        assign addr[k] = bus.ram_addr;

        if (L == 1) begin : g_async
            assign bus.ram_rdata = bus.ram_rd ? word_of(bus.ram_addr) : JUNK;
        end else begin : g_sync
            logic [29:0] st [L-1];
            always @(posedge clk) begin
                st[0] <= bus.ram_rd ? word_of(bus.ram_addr) : JUNK;
                for (int i = 1; i < L - 1; i++) st[i] <= st[i-1];
            end
            assign bus.ram_rdata = st[L-2];
        end
    end

    task automatic go_to(input int target);
        while (pos < target) begin
            @(negedge clk);
            pos++;
        end
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({dat[k], sync[k], rd[k], addr[k], bank[k], done[k], err[k]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs lat=%0d: dat=%h sync=%b rd=%b addr=%h bank=%b done=%b err=%b, expected all 0",
                         k + 1, dat[k], sync[k], rd[k], addr[k], bank[k], done[k], err[k]);
            end
        end
        nrst = 1'b1;
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                if (sync[k] !== 1'b0 || rd[k] !== 1'b0 || dat[k] !== '0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_quiet: %0d active samples, expected 0", bad);
        end
    endtask

    task automatic test_arm();
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sync[k] !== 1'b1 || dat[k] !== '0) begin
                errors++;
                $display("FAIL arm_sync lat=%0d: sync=%b dat=%h, expected sync=1 dat=0",
                         k + 1, sync[k], dat[k]);
            end
        end
        @(negedge clk);
        pos = 0;
    endtask

    task automatic test_first_slice();
        logic [29:0]   ed;
        logic          er;
        logic          es;
        logic [AW-1:0] ea;
        int l;
        for (int p = 0; p < SC; p++) begin
            for (int k = 0; k < 3; k++) begin
                l  = k + 1;
                ed = (p >= BL) ? word_of(mk(1'b0, 0, p - BL)) : '0;
                er = (p >= BL - l) && (p < SC - l);
                es = (p == SC - 1);
                ea = mk(1'b0, 0, p + l - BL);
                checks++;
                if (sync[k] !== es || rd[k] !== er || dat[k] !== ed
                    || (er && addr[k] !== ea)) begin
                    errors++;
                    $display("FAIL slice0_stream lat=%0d p=%0d: sync=%b rd=%b addr=%h dat=%h, expected sync=%b rd=%b addr=%h dat=%h",
                             l, p, sync[k], rd[k], addr[k], dat[k], es, er, ea, ed);
                end
            end
            go_to(pos + 1);
        end
    endtask

    task automatic test_bank_swap();
        go_to(at(4, 0) - 1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (done[k] !== 1'b0 || sync[k] !== 1'b1) begin
                errors++;
                $display("FAIL frame0_tail lat=%0d: done=%b sync=%b, expected done=0 sync=1",
                         k + 1, done[k], sync[k]);
            end
        end
        go_to(at(4, 0));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (done[k] !== 1'b1 || bank[k] !== 1'b0) begin
                errors++;
                $display("FAIL frame0_end_no_swap lat=%0d: done=%b bank=%b, expected done=1 bank=0",
                         k + 1, done[k], bank[k]);
            end
        end
        go_to(at(5, 200));
        frame_ready = 1'b1;
        go_to(at(5, 201));
        frame_ready = 1'b0;
        go_to(at(6, 10));
        frame_ready = 1'b1;
        go_to(at(6, 11));
        frame_ready = 1'b0;
        go_to(at(7, 80));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dat[k] !== word_of(mk(1'b0, 3, 0))) begin
                errors++;
                $display("FAIL slice3_word0 lat=%0d: dat=%h, expected %h",
                         k + 1, dat[k], word_of(mk(1'b0, 3, 0)));
            end
        end
        go_to(at(7, 511));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bank[k] !== 1'b0 || sync[k] !== 1'b1) begin
                errors++;
                $display("FAIL pre_swap lat=%0d: bank=%b sync=%b, expected bank=0 sync=1",
                         k + 1, bank[k], sync[k]);
            end
        end
        go_to(at(8, 0));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (done[k] !== 1'b1 || bank[k] !== 1'b1) begin
                errors++;
                $display("FAIL swap_at_done lat=%0d: done=%b bank=%b, expected done=1 bank=1",
                         k + 1, done[k], bank[k]);
            end
        end
        go_to(at(8, 1));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (done[k] !== 1'b0) begin
                errors++;
                $display("FAIL done_one_cycle lat=%0d: done=%b, expected 0", k + 1, done[k]);
            end
        end
        go_to(at(8, 80));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dat[k] !== word_of(mk(1'b1, 0, 0))) begin
                errors++;
                $display("FAIL bank1_word0 lat=%0d: dat=%h, expected %h",
                         k + 1, dat[k], word_of(mk(1'b1, 0, 0)));
            end
        end
    endtask

    task automatic test_realign();
        go_to(at(9, 100));
        position_sync = 1'b1;
        go_to(at(9, 101));
        position_sync = 1'b0;
        go_to(at(9, 510));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sync[k] !== 1'b0) begin
                errors++;
                $display("FAIL realign_no_early_sync lat=%0d: sync=%b, expected 0", k + 1, sync[k]);
            end
        end
        go_to(at(9, 511));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sync[k] !== 1'b1 || err[k] !== 1'b0) begin
                errors++;
                $display("FAIL realign_sync lat=%0d: sync=%b err=%b, expected sync=1 err=0",
                         k + 1, sync[k], err[k]);
            end
        end
        go_to(at(10, 0));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (err[k] !== 1'b1 || done[k] !== 1'b1 || bank[k] !== 1'b1) begin
                errors++;
                $display("FAIL realign_wrap lat=%0d: err=%b done=%b bank=%b, expected err=1 done=1 bank=1",
                         k + 1, err[k], done[k], bank[k]);
            end
        end
        go_to(at(10, 1));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (err[k] !== 1'b0) begin
                errors++;
                $display("FAIL resync_err_one_cycle lat=%0d: err=%b, expected 0", k + 1, err[k]);
            end
        end
        go_to(at(10, 80));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dat[k] !== word_of(mk(1'b1, 0, 0))) begin
                errors++;
                $display("FAIL realigned_slice0 lat=%0d: dat=%h, expected %h",
                         k + 1, dat[k], word_of(mk(1'b1, 0, 0)));
            end
        end
        go_to(at(10, 511));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sync[k] !== 1'b1) begin
                errors++;
                $display("FAIL realigned_period lat=%0d: sync=%b, expected 1", k + 1, sync[k]);
            end
        end
        go_to(at(11, 80));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dat[k] !== word_of(mk(1'b1, 1, 0))) begin
                errors++;
                $display("FAIL realigned_slice1 lat=%0d: dat=%h, expected %h",
                         k + 1, dat[k], word_of(mk(1'b1, 1, 0)));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        go_to(at(12, 300));
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dat[k] !== word_of(mk(1'b1, 2, 220))) begin
                errors++;
                $display("FAIL slice2_before_reset lat=%0d: dat=%h, expected %h",
                         k + 1, dat[k], word_of(mk(1'b1, 2, 220)));
            end
        end
        nrst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({dat[k], sync[k], rd[k], addr[k], bank[k], done[k], err[k]} !== '0) begin
                errors++;
                $display("FAIL async_reset lat=%0d: dat=%h sync=%b rd=%b addr=%h bank=%b done=%b err=%b, expected all 0",
                         k + 1, dat[k], sync[k], rd[k], addr[k], bank[k], done[k], err[k]);
            end
        end
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sync[k] !== 1'b1) begin
                errors++;
                $display("FAIL rearm_sync lat=%0d: sync=%b, expected 1", k + 1, sync[k]);
            end
        end
        @(negedge clk);
        pos = 0;
        go_to(80);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dat[k] !== word_of(mk(1'b0, 0, 0)) || bank[k] !== 1'b0) begin
                errors++;
                $display("FAIL rearm_slice0 lat=%0d: dat=%h bank=%b, expected dat=%h bank=0",
                         k + 1, dat[k], bank[k], word_of(mk(1'b0, 0, 0)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_first_slice();
        test_bank_swap();
        test_realign();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
